// File: rtl/sklansky_mw_add_ctrl.sv
// Multi-word add/subtract sequencer: streams NWORDS words, LSW first, through one
// external prefix adder, chaining carries and assembling the wide result.
module sklansky_mw_add_ctrl #(
    parameter  int ADDER_SIZE = 32,
    parameter  int NWORDS     = 4,
    localparam int W          = ADDER_SIZE - 1,
    localparam int N          = NWORDS * W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout
);

    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   result_q, result_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        if (state_q == RUN) begin
            add_a    = a_q[W-1:0];
            add_b    = b_q[W-1:0];
            add_cin  = carry_q;
            result_d = {add_sum, result_q[N-1:W]};
            carry_d  = add_cout;
            a_d      = a_q >> W;
            b_d      = b_q >> W;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
                idx_d   = '0;
                cout_d  = add_cout;
                // Top-word operand MSBs are the wide MSBs; b_q already holds post-inversion B.
                ovf_d   = a_q[W-1] ^ b_q[W-1] ^ add_sum[W-1] ^ add_cout;
            end
        end else if (start) begin
            state_d  = RUN;
            a_d      = op_a;
            b_d      = sub ? ~op_b : op_b;
            carry_d  = sub ? 1'b1 : cin;
            idx_d    = '0;
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_sklansky_mw_add_ctrl.sv
// Directed bench for sklansky_mw_add_ctrl with a behavioural word adder on the
// adder-side ports; expected values are hand-computed constants.
module tb_sklansky_mw_add_ctrl;

    localparam int ADDER_SIZE = 32;
    localparam int NWORDS     = 4;
    localparam int W          = ADDER_SIZE - 1;
    localparam int N          = NWORDS * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    sklansky_mw_add_ctrl #(.ADDER_SIZE(ADDER_SIZE), .NWORDS(NWORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the next posedge accepts the operation.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c);
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
    endtask

    // Steps negedges until done; lat = negedges after launch (NWORDS+1 expected).
    task automatic wait_done(input bit inject, output int lat, output int busy_cnt,
                             output logic [NWORDS-1:0] cin_seen, output logic first_busy,
                             output logic first_done, output logic [W-1:0] first_b);
        lat      = 0;
        busy_cnt = 0;
        cin_seen = '0;
        first_busy = 1'b0;
        first_done = 1'b0;
        first_b    = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start      = 1'b0;
                first_busy = busy;
                first_done = done;
                first_b    = add_b;
            end
            if (inject && i == 2) begin
                op_a  = {N{1'b1}};
                op_b  = {N{1'b1}};
                sub   = 1'b1;
                start = 1'b1;
            end
            if (inject && i == 3) start = 1'b0;
            if (busy) begin
                if (busy_cnt < NWORDS) cin_seen[busy_cnt] = add_cin;
                busy_cnt++;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("done_timeout", N'(0), N'(1));
    endtask

    int                lat, bcnt;
    logic [NWORDS-1:0] cmask;
    logic              fb, fd;
    logic [W-1:0]      fbw;

    initial begin
        rst = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0; op_a = '1; op_b = '1;
        repeat (2) @(negedge clk);
        check("rst_busy", N'(busy), N'(0));
        check("rst_done", N'(done), N'(0));
        check("rst_result", result, N'(0));
        check("rst_cout", N'(cout), N'(0));
        check("rst_ovf", N'(ovf), N'(0));
        check("rst_add_a", N'(add_a), N'(0));
        check("rst_add_b", N'(add_b), N'(0));
        check("rst_add_cin", N'(add_cin), N'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        // Carry across the word0/word1 boundary
        launch(N'(32'h7FFF_FFFF), N'(1), 1'b0, 1'b0);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("wb_latency", N'(lat), N'(NWORDS + 1));
        check("wb_busy_cycles", N'(bcnt), N'(4));
        check("wb_result", result, N'(36'h0_8000_0000));
        check("wb_cout", N'(cout), N'(0));
        check("wb_ovf", N'(ovf), N'(0));
        @(negedge clk);
        check("wb_done_pulse", N'(done), N'(0));
        check("idle_add_a", N'(add_a), N'(0));

        // All-ones ripple through every word
        launch({N{1'b1}}, N'(0), 1'b0, 1'b1);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("rip_result", result, N'(0));
        check("rip_cout", N'(cout), N'(1));
        check("rip_ovf", N'(ovf), N'(0));
        check("rip_cin_mask", N'(cmask), N'(4'b1111));
        @(negedge clk);

        // Subtract with borrow, then without
        launch(N'(5), N'(7), 1'b1, 1'b0);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("sub57_add_b_w0", N'(fbw), N'(31'h7FFF_FFF8));
        check("sub57_result", result, {{(N-4){1'b1}}, 4'hE});
        check("sub57_cout", N'(cout), N'(0));
        check("sub57_ovf", N'(ovf), N'(0));
        @(negedge clk);
        launch(N'(7), N'(5), 1'b1, 1'b1);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("sub75_result", result, N'(2));
        check("sub75_cout", N'(cout), N'(1));
        check("sub75_ovf", N'(ovf), N'(0));
        @(negedge clk);

        // Signed overflow: max positive + 1
        launch({1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("ovf_result", result, {1'b1, {(N-1){1'b0}}});
        check("ovf_ovf", N'(ovf), N'(1));
        check("ovf_cout", N'(cout), N'(0));
        @(negedge clk);

        // start mid-RUN is ignored
        launch(N'(100), N'(23), 1'b0, 1'b0);
        wait_done(1'b1, lat, bcnt, cmask, fb, fd, fbw);
        check("midrun_latency", N'(lat), N'(NWORDS + 1));
        check("midrun_result", result, N'(123));
        check("midrun_cout", N'(cout), N'(0));
        @(negedge clk);
        check("midrun_back_idle", N'(busy), N'(0));

        // Back-to-back: start during the DONE cycle
        launch(N'(10), N'(20), 1'b0, 1'b0);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("b2b_first_result", result, N'(30));
        launch(N'(40), N'(2), 1'b1, 1'b0);
        wait_done(1'b0, lat, bcnt, cmask, fb, fd, fbw);
        check("b2b_next_busy", N'(fb), N'(1));
        check("b2b_next_done", N'(fd), N'(0));
        check("b2b_second_latency", N'(lat), N'(NWORDS + 1));
        check("b2b_second_result", result, N'(38));
        check("b2b_second_cout", N'(cout), N'(1));
        @(negedge clk);

        // Abort with rst at edge k+2
        launch({N{1'b1}}, N'(3), 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", N'(busy), N'(0));
        check("abort_result", result, N'(0));
        check("abort_cout", N'(cout), N'(0));
        begin
            int seen_done = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || busy) seen_done++;
            end
            check("abort_no_done", N'(seen_done), N'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
